// File: rtl/sdcard_block_reader.sv
// CMD17 single-sector read sequencer: masters the SD register port byte-by-byte
// and streams the 512 data bytes into a sector buffer.
module sdcard_block_reader #(
  parameter int R1_TIMEOUT    = 8,
  parameter int TOKEN_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] lba,
  input  logic        high_capacity,
  output logic        busy,
  output logic        done,
  output logic [1:0]  error,
  output logic [7:0]  status,
  output logic        sd_cs_n,
  output logic [1:0]  if_a,
  output logic [7:0]  if_d_out,
  input  logic [7:0]  if_d_in,
  output logic        if_cs,
  output logic        if_we,
  output logic        if_oe,
  output logic [8:0]  buf_a,
  output logic [7:0]  buf_d,
  output logic        buf_we
);
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WR, S_POLL, S_RD, S_DONE} state_t;
  typedef enum logic [2:0] {P_PRE, P_CMD, P_R1, P_TOKEN, P_DATA, P_CRC, P_FIN} phase_t;

  localparam logic [15:0] R1_LAST  = 16'(R1_TIMEOUT - 1);
  localparam logic [15:0] TOK_LAST = 16'(TOKEN_TIMEOUT - 1);

  state_t      r_state;
  phase_t      r_phase;
  logic [15:0] r_cnt;
  logic [47:0] r_cmd;
  logic        r_busy, r_done, r_cs_n;
  logic [1:0]  r_error, r_if_a;
  logic [7:0]  r_status, r_if_d_out;
  logic        r_if_cs, r_if_we, r_if_oe, r_buf_we;
  logic [8:0]  r_buf_a;

  phase_t      w_ph_n;
  logic [7:0]  w_tx_n, w_stat_n;
  logic [15:0] w_cnt_n;
  logic [1:0]  w_err_n;
  logic        w_end;

  // Decision taken at the end of each byte transfer, using the byte just read.
  always_comb begin
    w_ph_n   = r_phase;
    w_tx_n   = 8'hFF;
    w_cnt_n  = r_cnt + 16'd1;
    w_err_n  = r_error;
    w_stat_n = r_status;
    w_end    = 1'b0;
    case (r_phase)
      P_PRE: begin w_ph_n = P_CMD; w_tx_n = r_cmd[47:40]; w_cnt_n = '0; end
      P_CMD:
        if (r_cnt == 16'd5) begin w_ph_n = P_R1; w_cnt_n = '0; end
        else w_tx_n = r_cmd[39:32];
      P_R1:
        if (if_d_in[7]) begin
          if (r_cnt == R1_LAST) begin w_ph_n = P_FIN; w_err_n = 2'b11; end
        end else begin
          w_stat_n = if_d_in;
          w_cnt_n  = '0;
          if (if_d_in != 8'h00) begin w_ph_n = P_FIN; w_err_n = 2'b01; end
          else w_ph_n = P_TOKEN;
        end
      P_TOKEN:
        if (if_d_in == 8'hFE) begin w_ph_n = P_DATA; w_cnt_n = '0; end
        else if (if_d_in == 8'hFF) begin
          if (r_cnt == TOK_LAST) begin w_ph_n = P_FIN; w_err_n = 2'b11; end
        end else begin
          w_stat_n = if_d_in; w_ph_n = P_FIN; w_err_n = 2'b10;
        end
      P_DATA: if (r_cnt == 16'd511) begin w_ph_n = P_CRC; w_cnt_n = '0; end
      P_CRC:  if (r_cnt == 16'd1) w_ph_n = P_FIN;
      default: w_end = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;  r_phase <= P_PRE;  r_cnt <= '0;  r_cmd <= '0;
      r_busy <= 1'b0;  r_done <= 1'b0;  r_error <= '0;  r_status <= '0;
      r_cs_n <= 1'b1;  r_if_a <= '0;  r_if_d_out <= '0;
      r_if_cs <= 1'b0;  r_if_we <= 1'b0;  r_if_oe <= 1'b0;
      r_buf_a <= '0;  r_buf_we <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_buf_we <= 1'b0;
      case (r_state)
        S_IDLE:
          if (start) begin
            r_busy   <= 1'b1;
            r_error  <= '0;
            r_status <= '0;
            r_cmd    <= {8'h51, (high_capacity ? lba : {lba[22:0], 9'd0}), 8'h95};
            r_phase  <= P_PRE;
            r_cnt    <= '0;
            r_state  <= S_SETUP;
            r_if_cs  <= 1'b1;  r_if_we <= 1'b1;  r_if_a <= 2'd0;  r_if_d_out <= 8'h08;
          end
        S_SETUP: begin r_state <= S_WR; r_if_a <= 2'd1; r_if_d_out <= 8'hFF; end
        S_WR:    begin r_state <= S_POLL; r_if_we <= 1'b0; r_if_oe <= 1'b1; r_if_a <= 2'd0; end
        S_POLL:
          if (if_d_in[7]) begin
            r_state <= S_RD;
            r_if_a  <= 2'd1;
            if (r_phase == P_DATA) begin r_buf_we <= 1'b1; r_buf_a <= r_cnt[8:0]; end
          end
        S_RD: begin
          r_phase  <= w_ph_n;
          r_cnt    <= w_cnt_n;
          r_error  <= w_err_n;
          r_status <= w_stat_n;
          if (r_phase == P_CMD) r_cmd <= {r_cmd[39:0], 8'h00};
          if (r_phase == P_PRE) r_cs_n <= 1'b0;
          // CS is released before the trailing byte so the card sees clocks with CS high
          if (w_ph_n == P_FIN && r_phase != P_FIN) r_cs_n <= 1'b1;
          if (w_end) begin
            r_state <= S_DONE;  r_done <= 1'b1;
            r_if_cs <= 1'b0;  r_if_oe <= 1'b0;  r_if_a <= '0;  r_if_d_out <= '0;
          end else begin
            r_state <= S_WR;
            r_if_we <= 1'b1;  r_if_oe <= 1'b0;  r_if_a <= 2'd1;  r_if_d_out <= w_tx_n;
          end
        end
        S_DONE:  begin r_busy <= 1'b0; r_state <= S_IDLE; end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign status   = r_status;
  assign sd_cs_n  = r_cs_n;
  assign if_a     = r_if_a;
  assign if_d_out = r_if_d_out;
  assign if_cs    = r_if_cs;
  assign if_we    = r_if_we;
  assign if_oe    = r_if_oe;
  assign buf_a    = r_buf_a;
  assign buf_we   = r_buf_we;
  // Read data goes straight through in the capture cycle
  assign buf_d    = r_buf_we ? if_d_in : 8'h00;
endmodule

// File: tb/tb_sdcard_block_reader.sv
// Scoreboard bench: a byte-level card/interface model answers transfers, a monitor
// checks MOSI bytes, buffer writes and completion against queued expectations.
module tb_sdcard_block_reader;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, high_capacity = 1'b0;
  logic [31:0] lba = '0;
  logic        busy, done, sd_cs_n, if_cs, if_we, if_oe, buf_we;
  logic [1:0]  error, if_a;
  logic [7:0]  status, if_d_out, if_d_in, buf_d;
  logic [8:0]  buf_a;

  always #5 clk = ~clk;

  sdcard_block_reader dut (
    .clk(clk), .rst(rst), .start(start), .lba(lba), .high_capacity(high_capacity),
    .busy(busy), .done(done), .error(error), .status(status), .sd_cs_n(sd_cs_n),
    .if_a(if_a), .if_d_out(if_d_out), .if_d_in(if_d_in), .if_cs(if_cs), .if_we(if_we),
    .if_oe(if_oe), .buf_a(buf_a), .buf_d(buf_d), .buf_we(buf_we)
  );

  // Interface + card model: each reg1 write returns the next scripted byte (0xFF when empty).
  logic [7:0] resp_q[$];
  logic       m_avail;
  logic [7:0] m_rx;
  int         m_lat;
  assign if_d_in = (if_a == 2'd0) ? {m_avail, 7'd0} : (if_a == 2'd1 ? m_rx : 8'h00);
  always @(posedge clk) begin
    if (rst) begin
      m_avail <= 1'b0; m_lat <= 0; m_rx <= 8'h00;
    end else if (if_cs && if_we && if_a == 2'd1) begin
      m_avail <= 1'b0;
      m_lat   <= 2;
      if (resp_q.size() > 0) m_rx <= resp_q.pop_front();
      else m_rx <= 8'hFF;
    end else if (m_lat > 0) begin
      m_lat <= m_lat - 1;
      if (m_lat == 1) m_avail <= 1'b1;
    end
  end

  logic [7:0]  exp_mosi[$];
  logic [16:0] exp_buf[$];
  logic [9:0]  exp_done[$];
  int n_vec = 0, n_err = 0, done_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_ev(input string name, input logic [31:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got %h, nothing expected (t=%0t)", name, act, $time);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (if_cs && if_we) begin
        if (if_a == 2'd1) begin
          if (exp_mosi.size() == 0) fail_ev("mosi_extra", {24'd0, if_d_out});
          else chk("mosi", {24'd0, if_d_out}, {24'd0, exp_mosi.pop_front()});
        end else if (if_a == 2'd0) chk("reg0_write", {24'd0, if_d_out}, 32'h08);
        else fail_ev("bad_reg_write", {30'd0, if_a});
      end
      if (buf_we) begin
        if (exp_buf.size() == 0) fail_ev("buf_extra", {15'd0, buf_a, buf_d});
        else chk("buf_write", {15'd0, buf_a, buf_d}, {15'd0, exp_buf.pop_front()});
      end
      if (done) begin
        done_seen++;
        if (exp_done.size() == 0) fail_ev("done_extra", {22'd0, error, status});
        else begin
          chk("done_err_status", {22'd0, error, status}, {22'd0, exp_done.pop_front()});
          chk("cs_n_at_done", {31'd0, sd_cs_n}, 32'd1);
          chk("busy_at_done", {31'd0, busy}, 32'd1);
        end
      end
    end
  end

  task automatic pulse_start(input logic hc, input logic [31:0] l);
    @(negedge clk);
    high_capacity = hc; lba = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_cmd(input logic [31:0] addr);
    exp_mosi.push_back(8'hFF);
    exp_mosi.push_back(8'h51);
    exp_mosi.push_back(addr[31:24]);
    exp_mosi.push_back(addr[23:16]);
    exp_mosi.push_back(addr[15:8]);
    exp_mosi.push_back(addr[7:0]);
    exp_mosi.push_back(8'h95);
    for (int i = 0; i < 7; i++) resp_q.push_back(8'hFF);
  endtask

  task automatic push_ff(input int n);
    for (int i = 0; i < n; i++) exp_mosi.push_back(8'hFF);
  endtask

  task automatic wait_done(input int budget);
    int s, c;
    s = done_seen;
    c = 0;
    while (done_seen == s && c < budget) begin @(posedge clk); c++; end
    if (done_seen == s) fail_ev("done_timeout", c);
    else begin
      @(negedge clk);
      chk("busy_after_done", {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic check_empty();
    chk("mosi_q_empty", exp_mosi.size(), 0);
    chk("buf_q_empty", exp_buf.size(), 0);
    chk("done_q_empty", exp_done.size(), 0);
    resp_q.delete();
  endtask

  // Full successful read: R1=00, two idle bytes, token, data i&FF, CRC.
  task automatic normal_read(input logic hc, input logic [31:0] l, input logic [31:0] addr);
    push_cmd(addr);
    resp_q.push_back(8'h00);
    resp_q.push_back(8'hFF);
    resp_q.push_back(8'hFF);
    resp_q.push_back(8'hFE);
    for (int i = 0; i < 512; i++) begin
      resp_q.push_back(i[7:0]);
      exp_buf.push_back({i[8:0], i[7:0]});
    end
    resp_q.push_back(8'hAA);
    resp_q.push_back(8'h55);
    push_ff(1 + 3 + 512 + 2 + 1);
    exp_done.push_back({2'b00, 8'h00});
    pulse_start(hc, l);
    wait_done(10000);
    check_empty();
  endtask

  initial begin
    int c, s;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err_status", {22'd0, error, status}, 32'd0);
    chk("rst_cs_n", {31'd0, sd_cs_n}, 32'd1);
    chk("rst_strobes", {28'd0, if_cs, if_we, if_oe, buf_we}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    normal_read(1'b1, 32'h0000_1234, 32'h0000_1234);
    normal_read(1'b0, 32'h0000_0003, 32'h0000_0600);

    // R1 error after three idle polls
    push_cmd(32'h0A0B_0C0D);
    resp_q.push_back(8'hFF); resp_q.push_back(8'hFF); resp_q.push_back(8'hFF);
    resp_q.push_back(8'h04);
    push_ff(4 + 1);
    exp_done.push_back({2'b01, 8'h04});
    pulse_start(1'b1, 32'h0A0B_0C0D);
    wait_done(2000);
    check_empty();

    // Data-error token; byte address truncated to 32 bits
    push_cmd(32'h579B_DE00);
    resp_q.push_back(8'h00); resp_q.push_back(8'h08);
    push_ff(1 + 1 + 1);
    exp_done.push_back({2'b10, 8'h08});
    pulse_start(1'b0, 32'h00AB_CDEF);
    wait_done(2000);
    check_empty();

    // Token timeout: exactly 4096 token polls
    push_cmd(32'h0000_0007);
    resp_q.push_back(8'h00);
    push_ff(1 + 4096 + 1);
    exp_done.push_back({2'b11, 8'h00});
    pulse_start(1'b1, 32'h0000_0007);
    wait_done(40000);
    check_empty();

    // R1 timeout: 8 polls
    push_cmd(32'h0000_0009);
    push_ff(8 + 1);
    exp_done.push_back({2'b11, 8'h00});
    pulse_start(1'b1, 32'h0000_0009);
    wait_done(2000);
    check_empty();

    // Reset while data byte 100 is being written
    push_cmd(32'h0000_1234);
    resp_q.push_back(8'h00); resp_q.push_back(8'hFE);
    for (int i = 0; i < 512; i++) resp_q.push_back(i[7:0]);
    for (int i = 0; i <= 100; i++) exp_buf.push_back({i[8:0], i[7:0]});
    push_ff(1 + 1 + 101);
    s = done_seen;
    pulse_start(1'b1, 32'h0000_1234);
    c = 0;
    do begin @(negedge clk); c++; end while (!(buf_we && buf_a == 9'd100) && c < 5000);
    if (!(buf_we && buf_a == 9'd100)) fail_ev("data100_timeout", c);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_cs_n", {31'd0, sd_cs_n}, 32'd1);
    chk("midrst_strobes", {28'd0, if_cs, if_we, if_oe, buf_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_no_done", done_seen, s);
    check_empty();
    normal_read(1'b1, 32'h00C0_FFEE, 32'h00C0_FFEE);

    // Second start during CMD must not disturb the address bytes
    push_cmd(32'h0102_0304);
    resp_q.push_back(8'h04);
    push_ff(1 + 1);
    exp_done.push_back({2'b01, 8'h04});
    pulse_start(1'b1, 32'h0102_0304);
    repeat (13) @(negedge clk);
    pulse_start(1'b0, 32'hFFFF_FFFF);
    wait_done(2000);
    check_empty();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
